sine_offset_gen: RTL and testbench

//  Sampled sinusoid generator with programmable amplitude and DC offset; the source side of the DC offset

---
 rtl/seq_decomp_pkg.sv | 43 ++++
 rtl/sine_offset_gen_lut.sv | 41 ++++
 rtl/sine_offset_gen.sv | 218 +++++++++++++++++++++
 tb/tb_sine_offset_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_decomp_pkg.sv
// Shared types and constants for the sequence-decomposer test path: FSM states,
// sine quadrants and output saturation limits.
package seq_decomp_pkg;

  localparam int unsigned SINE_M      = 14;
  localparam int unsigned SINE_PW     = 16;
  localparam int unsigned SINE_LUT_AW = 6;

  localparam int SAT_HI = (2 ** (SINE_M - 1)) - 1;
  localparam int SAT_LO = -(2 ** (SINE_M - 1));

  localparam logic signed [SINE_M:0]   SUM_HI    = (SINE_M + 1)'(SAT_HI);
  localparam logic signed [SINE_M:0]   SUM_LO    = (SINE_M + 1)'(SAT_LO);
  localparam logic signed [SINE_M-1:0] SAMPLE_HI = SINE_M'(SAT_HI);
  localparam logic signed [SINE_M-1:0] SAMPLE_LO = SINE_M'(SAT_LO);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // Clamp an (M+1)-bit sum into the signed M-bit output range.
  function automatic logic signed [SINE_M-1:0] sat_sample(input logic signed [SINE_M:0] s);
    logic signed [SINE_M-1:0] r;
    if (s > SUM_HI) begin
      r = SAMPLE_HI;
    end else if (s < SUM_LO) begin
      r = SAMPLE_LO;
    end else begin
      r = s[SINE_M-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sine_offset_gen_lut.sv
// Registered quarter-wave sine ROM; table is fixed at elaboration, read takes one enabled cycle.
module sine_quarter_lut #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  localparam int unsigned DEPTH = 2 ** AW;

  // Half-index sampling keeps the table symmetric about the quadrant edges.
  function automatic logic [DW-1:0] lut_entry(input int k);
    real x;
    x = real'((2 ** DW) - 1) * $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(DEPTH));
    return DW'($rtoi(x + 0.5));
  endfunction

  logic [DW-1:0] rom [DEPTH];
  logic [DW-1:0] data_q, data_d;

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_rom
    assign rom[k] = lut_entry(k);
  end

  always_comb begin
    data_d = data_q;
    if (en) data_d = rom[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/sine_offset_gen.sv
// Sampled sinusoid with programmable amplitude and wrap-synchronised DC offset.
// Define OFFSET_RAMP_EN to slew the offset 1 LSB per sample instead of stepping it.
module sine_offset_gen
  import seq_decomp_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [SINE_PW-1:0]         phase_inc,
  input  logic [SINE_M-2:0]          amp,
  input  logic signed [SINE_M-1:0]   offset_in,
  input  logic                       offset_ld,
  output logic signed [SINE_M-1:0]   vout,
  output logic                       vout_valid,
  output logic                       zc,
  output logic                       offset_busy
);

  localparam int unsigned M      = SINE_M;
  localparam int unsigned PW     = SINE_PW;
  localparam int unsigned LUT_AW = SINE_LUT_AW;
  localparam int unsigned PRODW  = 2 * (M - 1);

  // Phase accumulator and wrap tracking
  logic [PW-1:0]        phase_q, phase_d;
  logic [PW:0]          phase_sum_c;
  logic                 wrap_c;
  logic                 after_wrap_q, after_wrap_d;

  // Offset control
  fsm_state_e           state_q, state_d;
  logic signed [M-1:0]  active_q, active_d;
  logic signed [M-1:0]  pending_q, pending_d;
  logic                 busy_q, busy_d;
`ifdef OFFSET_RAMP_EN
  logic                 ramping_q, ramping_d;
`endif

  // Pipeline
  quad_e                quad_c;
  logic [LUT_AW-1:0]    raw_addr_c, lut_addr_c;
  logic [M-2:0]         lut_data;
  logic                 s1_valid_q, s1_valid_d, s1_neg_q, s1_neg_d, s1_zc_q, s1_zc_d;
  logic signed [M-1:0]  s1_off_q, s1_off_d;
  logic [PRODW-1:0]     prod_c;
  logic                 s2_valid_q, s2_valid_d, s2_neg_q, s2_neg_d, s2_zc_q, s2_zc_d;
  logic [M-2:0]         s2_mag_q, s2_mag_d;
  logic signed [M-1:0]  s2_off_q, s2_off_d;
  logic signed [M:0]    smag_c, sum_c;
  logic signed [M-1:0]  vout_q, vout_d;
  logic                 vout_valid_q, vout_valid_d, zc_q, zc_d;

  assign phase_sum_c = {1'b0, phase_q} + {1'b0, phase_inc};
  assign wrap_c      = en & phase_sum_c[PW];

  always_comb begin
    phase_d      = phase_q;
    after_wrap_d = after_wrap_q;
    if (en) begin
      phase_d      = phase_sum_c[PW-1:0];
      after_wrap_d = phase_sum_c[PW];
    end
  end

  // Offset FSM: a load parks the value in pending until an enabled wrap.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
`ifdef OFFSET_RAMP_EN
    ramping_d = ramping_q;
`endif
    if (offset_ld) pending_d = offset_in;
    unique case (state_q)
      ST_IDLE: begin
        if (offset_ld)  state_d = ST_PEND;
        else if (en)    state_d = ST_RUN;
      end
      ST_RUN: begin
        if (offset_ld)  state_d = ST_PEND;
      end
      ST_PEND: begin
`ifdef OFFSET_RAMP_EN
        if (en && (wrap_c || ramping_q)) begin
          if (active_q < pending_q)      active_d = active_q + M'(1);
          else if (active_q > pending_q) active_d = active_q - M'(1);
          if (active_d == pending_d) begin
            state_d   = ST_RUN;
            ramping_d = 1'b0;
          end else begin
            ramping_d = 1'b1;
          end
        end
`else
        if (wrap_c) begin
          active_d = pending_q;
          if (!offset_ld) state_d = ST_RUN;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= '0;
      after_wrap_q <= 1'b0;
      state_q      <= ST_IDLE;
      active_q     <= '0;
      pending_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      after_wrap_q <= after_wrap_d;
      state_q      <= state_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
    end
  end

`ifdef OFFSET_RAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ramping_q <= 1'b0;
    else        ramping_q <= ramping_d;
  end
`endif

  // S1 address: quadrants 1 and 3 run the quarter table backwards.
  always_comb begin
    quad_c     = quad_e'(phase_q[PW-1 -: 2]);
    raw_addr_c = phase_q[PW-3 -: LUT_AW];
    lut_addr_c = ((quad_c == QUAD_1) || (quad_c == QUAD_3)) ? ~raw_addr_c : raw_addr_c;
  end

  sine_quarter_lut #(
    .AW (LUT_AW),
    .DW (M - 1)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .addr  (lut_addr_c),
    .data  (lut_data)
  );

  assign prod_c = PRODW'(lut_data) * PRODW'(amp);
  assign smag_c = s2_neg_q ? -$signed({2'b00, s2_mag_q}) : $signed({2'b00, s2_mag_q});
  assign sum_c  = smag_c + {s2_off_q[M-1], s2_off_q};

  // Each sample carries the offset that was active while its phase sat in the accumulator.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_neg_d     = s1_neg_q;
    s1_zc_d      = s1_zc_q;
    s1_off_d     = s1_off_q;
    s2_valid_d   = s2_valid_q;
    s2_neg_d     = s2_neg_q;
    s2_zc_d      = s2_zc_q;
    s2_mag_d     = s2_mag_q;
    s2_off_d     = s2_off_q;
    vout_d       = vout_q;
    vout_valid_d = 1'b0;
    zc_d         = 1'b0;
    if (en) begin
      s1_valid_d   = 1'b1;
      s1_neg_d     = (quad_c == QUAD_2) || (quad_c == QUAD_3);
      s1_zc_d      = after_wrap_q;
      s1_off_d     = active_q;
      s2_valid_d   = s1_valid_q;
      s2_neg_d     = s1_neg_q;
      s2_zc_d      = s1_zc_q;
      s2_mag_d     = (M - 1)'(prod_c >> (M - 1));
      s2_off_d     = s1_off_q;
      vout_d       = sat_sample(sum_c);
      vout_valid_d = s2_valid_q;
      zc_d         = s2_zc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_neg_q     <= 1'b0;
      s1_zc_q      <= 1'b0;
      s1_off_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_neg_q     <= 1'b0;
      s2_zc_q      <= 1'b0;
      s2_mag_q     <= '0;
      s2_off_q     <= '0;
      vout_q       <= '0;
      vout_valid_q <= 1'b0;
      zc_q         <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_neg_q     <= s1_neg_d;
      s1_zc_q      <= s1_zc_d;
      s1_off_q     <= s1_off_d;
      s2_valid_q   <= s2_valid_d;
      s2_neg_q     <= s2_neg_d;
      s2_zc_q      <= s2_zc_d;
      s2_mag_q     <= s2_mag_d;
      s2_off_q     <= s2_off_d;
      vout_q       <= vout_d;
      vout_valid_q <= vout_valid_d;
      zc_q         <= zc_d;
    end
  end

  assign vout        = vout_q;
  assign vout_valid  = vout_valid_q;
  assign zc          = zc_q;
  assign offset_busy = busy_q;

endmodule

// File: tb/tb_sine_offset_gen.sv
// Randomised self-checking bench for sine_offset_gen against a sample-level reference model.
module tb_sine_offset_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [15:0]        phase_inc;
  logic [12:0]        amp;
  logic signed [13:0] offset_in;
  logic               offset_ld;
  logic signed [13:0] vout;
  logic               vout_valid;
  logic               zc;
  logic               offset_busy;

  always #5 clk = ~clk;

  sine_offset_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .phase_inc   (phase_inc),
    .amp         (amp),
    .offset_in   (offset_in),
    .offset_ld   (offset_ld),
    .vout        (vout),
    .vout_valid  (vout_valid),
    .zc          (zc),
    .offset_busy (offset_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sample is offset + signed scaled quarter-wave value,
  // computed from the phase when it was taken; outputs appear 3 enabled cycles later.
  typedef struct {
    bit v;
    int ph;
    int off;
    bit zc;
    int mag;
  } item_t;

  int    m_phase;
  bit    m_after_wrap;
  int    m_act, m_pend;
  bit    m_has_pend, m_ramping;
  item_t m_s1, m_s2;
  int    m_vout;
  bit    m_vv, m_zc;

  function automatic int lut_val(input int k);
    real x;
    x = 8191.0 * $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / 64.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic int mag_of(input int ph, input int a);
    int q;
    int idx;
    q   = ph / 16384;
    idx = (ph % 16384) / 256;
    if (q % 2 == 1) idx = 63 - idx;
    return (lut_val(idx) * a) / 8192;
  endfunction

  function automatic int sat(input int v);
    if (v > 8191)  return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_after_wrap = 0;
    m_act = 0; m_pend = 0; m_has_pend = 0; m_ramping = 0;
    m_s1 = '{0, 0, 0, 0, 0};
    m_s2 = '{0, 0, 0, 0, 0};
    m_vout = 0; m_vv = 0; m_zc = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit wrap;
    wrap = 0;
    if (en) begin
      if (m_s2.v) m_vout = sat(((m_s2.ph >= 32768) ? -m_s2.mag : m_s2.mag) + m_s2.off);
      m_vv = m_s2.v;
      m_zc = m_s2.zc;
      m_s2 = m_s1;
      m_s2.mag = mag_of(m_s1.ph, int'(amp));
      m_s1 = '{1, m_phase, m_act, m_after_wrap, 0};
      nxt = m_phase + int'(phase_inc);
      wrap = (nxt >= 65536);
      m_phase = nxt % 65536;
      m_after_wrap = wrap;
    end else begin
      m_vv = 0;
      m_zc = 0;
    end
`ifdef OFFSET_RAMP_EN
    if (en && m_has_pend && (wrap || m_ramping)) begin
      if (m_act < m_pend)      m_act++;
      else if (m_act > m_pend) m_act--;
      if (offset_ld) m_pend = int'(offset_in);
      m_ramping   = (m_act != m_pend);
      m_has_pend  = m_ramping;
    end else if (offset_ld) begin
      m_pend = int'(offset_in);
      m_has_pend = 1;
    end
`else
    if (wrap && m_has_pend) begin
      m_act = m_pend;
      m_has_pend = 0;
    end
    if (offset_ld) begin
      m_pend = int'(offset_in);
      m_has_pend = 1;
    end
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("vout_valid", int'(vout_valid), int'(m_vv));
    check_val("zc", int'(zc), int'(m_zc));
    check_val("offset_busy", int'(offset_busy), int'(m_has_pend));
    check_val("vout", int'(vout), m_vout);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_vout", int'(vout), 0);
    check_val("rst_valid", int'(vout_valid), 0);
    check_val("rst_zc", int'(zc), 0);
    check_val("rst_busy", int'(offset_busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_ld(input int value);
    offset_in = 14'(value);
    offset_ld = 1'b1;
    cycle();
    offset_ld = 1'b0;
  endtask

  initial begin
    int zc_cnt;
    int vmax;
    int guard;
    rst_n = 1'b0; en = 1'b0; phase_inc = 16'd1024; amp = 13'd8191;
    offset_in = '0; offset_ld = 1'b0;
    model_reset();
    apply_reset();

    // Full-scale 64-sample sine.
    en = 1'b1;
    run(200);
    zc_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      cycle();
      zc_cnt += int'(zc);
    end
    check_val("zc_per_128", zc_cnt, 2);

    // Offset +1000 loaded mid-period; positive peak must clip.
    guard = 0;
    while (m_phase != 32768 && guard < 200) begin cycle(); guard++; end
    check_val("reach_mid", int'(guard < 200), 1);
    pulse_ld(1000);
    vmax = -9000;
    for (int i = 0; i < 140; i++) begin
      cycle();
      if (vout_valid && int'(vout) > vmax) vmax = int'(vout);
    end
    check_val("peak_sat", vmax, 8191);

    // Load -500 on the wrap cycle: applies one period later.
    guard = 0;
    while ((m_phase + int'(phase_inc)) < 65536 && guard < 200) begin cycle(); guard++; end
    check_val("reach_wrap", int'(guard < 200), 1);
    pulse_ld(-500);
    check_val("busy_after_wrap_ld", int'(offset_busy), 1);
    run(150);

    // en alternating every cycle.
    for (int i = 0; i < 300; i++) begin
      en = (i % 2 == 0);
      cycle();
    end
    en = 1'b1;

    // phase_inc = 0: no wrap, pending offset stays parked.
    phase_inc = 16'd0;
    pulse_ld(300);
    run(100);
    check_val("busy_inc0", int'(offset_busy), 1);
    phase_inc = 16'd1024;

    // Small ramp/step target at the next wrap.
    pulse_ld(20);
    run(160);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(3) != 0);
      offset_ld = ($urandom_range(49) == 0);
      if ($urandom_range(3) == 0) offset_in = 14'($urandom_range(16383));
      else                        offset_in = 14'(int'($urandom_range(3000)) - 1500);
      if ($urandom_range(199) == 0) begin
        if ($urandom_range(9) == 0) phase_inc = 16'd0;
        else                        phase_inc = 16'($urandom_range(4095));
      end
      if ($urandom_range(99) == 0) amp = 13'($urandom);
      cycle();
    end
    offset_ld = 1'b0;

    // Asynchronous reset while an offset is pending.
    en = 1'b1; phase_inc = 16'd1024; amp = 13'd8191;
    run(5);
    pulse_ld(700);
    run(10);
    check_val("busy_pre_rst", int'(offset_busy), 1);
    apply_reset();
    run(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
